// File: rtl/instr_fetch_queue_pkg.sv
// Shared definitions for the instruction fetch queue: opcodes, default sizes
// and the fetch state encoding.
package instr_fetch_queue_pkg;

   localparam int unsigned DEF_AW    = 8;
   localparam int unsigned DEF_DEPTH = 4;

   localparam logic [5:0] OP_NOP  = 6'b000000;
   localparam logic [5:0] OP_JMP  = 6'b000010;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_BLT  = 6'b000101;
   localparam logic [5:0] OP_BGT  = 6'b000110;
   localparam logic [5:0] OP_HALT = 6'b111111;

   typedef enum logic [1:0] {
      ST_FETCH,
      ST_STALL,
      ST_STOPPED
   } fetch_state_t;

   function automatic logic is_halt(input logic [31:0] word);
      return word[31:26] == OP_HALT;
   endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous DEPTH-entry FIFO holding instruction word and next-PC pairs,
// with a flush that empties it in one cycle.
module ifq_fifo #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk1,
   input  logic                     reset,
   input  logic                     flush,
   input  logic                     push,
   input  logic [31:0]              push_ir,
   input  logic [31:0]              push_npc,
   input  logic                     pop,
   output logic [31:0]              head_ir,
   output logic [31:0]              head_npc,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [31:0]   ir_mem  [DEPTH];
   logic [31:0]   npc_mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty    = (count == '0);
   assign full     = (count == CW'(DEPTH));
   assign do_pop   = pop && !empty;
   // A full queue still accepts a push when the head leaves in the same cycle.
   assign do_push  = push && (!full || do_pop);
   assign head_ir  = ir_mem[rd_ptr];
   assign head_npc = npc_mem[rd_ptr];

   always_ff @(posedge clk1) begin
      if (do_push) begin
         ir_mem[wr_ptr]  <= push_ir;
         npc_mem[wr_ptr] <= push_npc;
      end
   end

   always_ff @(posedge clk1) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: PC, one-deep in-flight tracking, fetch state
// machine, and a decode-facing queue of fetched words.
module instr_fetch_queue
   import instr_fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH = DEF_DEPTH,
   parameter int unsigned AW    = DEF_AW
) (
   input  logic          clk1,
   input  logic          reset,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [31:0]   imem_rdata,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc,
   input  logic          halt,
   output logic          id_valid,
   output logic [31:0]   id_ir,
   output logic [31:0]   id_npc,
   input  logic          id_ready,
   output logic          fetch_stopped
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t  state;
   logic [AW-1:0] pc;
   logic [AW-1:0] flight_addr;
   logic [AW-1:0] resp_npc;
   logic          in_flight;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          halt_push;
   logic          room;
   logic          issue;
   logic [31:0]   head_ir;
   logic [31:0]   head_npc;

   assign push      = in_flight && !redirect_valid;
   assign halt_push = push && is_halt(imem_rdata);
   assign room      = !full && ((count + CW'(in_flight)) < CW'(DEPTH));
   // A Halt word arriving this cycle already blocks the request behind it.
   assign issue     = !reset && !halt && !redirect_valid && (state != ST_STOPPED)
                      && !halt_push && room;
   assign resp_npc  = flight_addr + AW'(1);

   assign imem_req      = issue;
   assign imem_addr     = issue ? pc : '0;
   assign id_valid      = !reset && !empty;
   assign id_ir         = id_valid ? head_ir  : '0;
   assign id_npc        = id_valid ? head_npc : '0;
   assign fetch_stopped = !reset && (state == ST_STOPPED);
   assign pop           = id_valid && id_ready && !redirect_valid;

   always_ff @(posedge clk1) begin
      if (reset) begin
         pc          <= '0;
         flight_addr <= '0;
         in_flight   <= 1'b0;
         state       <= ST_FETCH;
      end else if (redirect_valid) begin
         pc        <= redirect_pc;
         in_flight <= 1'b0;
         state     <= ST_FETCH;
      end else begin
         in_flight <= issue;
         if (issue) begin
            pc          <= pc + AW'(1);
            flight_addr <= pc;
         end
         if (halt_push || state == ST_STOPPED) state <= ST_STOPPED;
         else if (halt || !room)               state <= ST_STALL;
         else                                  state <= ST_FETCH;
      end
   end

   ifq_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk1     (clk1),
      .reset    (reset),
      .flush    (redirect_valid),
      .push     (push),
      .push_ir  (imem_rdata),
      .push_npc (32'(resp_npc)),
      .pop      (pop),
      .head_ir  (head_ir),
      .head_npc (head_npc),
      .count    (count),
      .full     (full),
      .empty    (empty)
   );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: directed scenarios queue the words
// decode should receive; a negedge monitor compares every accepted word.
module tb_instr_fetch_queue;

   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk1 = 1'b0;
   logic          reset = 1'b1;
   logic          imem_req;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_rdata = '0;
   logic          redirect_valid = 1'b0;
   logic [AW-1:0] redirect_pc = '0;
   logic          halt = 1'b0;
   logic          id_valid;
   logic [31:0]   id_ir;
   logic [31:0]   id_npc;
   logic          id_ready = 1'b0;
   logic          fetch_stopped;

   logic [31:0] mem [256];

   typedef struct {
      logic [31:0] ir;
      logic [31:0] npc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   always #5 clk1 = ~clk1;

   instr_fetch_queue #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) dut (
      .clk1           (clk1),
      .reset          (reset),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .id_valid       (id_valid),
      .id_ir          (id_ir),
      .id_npc         (id_npc),
      .id_ready       (id_ready),
      .fetch_stopped  (fetch_stopped)
   );

   // Instruction memory: one-cycle read latency.
   always @(posedge clk1) imem_rdata <= imem_req ? mem[imem_addr] : '0;

   function automatic logic [31:0] word_at(input int unsigned a);
      return 32'h0400_0000 + 32'(a) + 32'd1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic expect_raw(input logic [31:0] ir, input logic [31:0] npc);
      exp_t e;
      e.ir  = ir;
      e.npc = npc;
      sb.push_back(e);
   endtask

   task automatic expect_word(input int unsigned a);
      expect_raw(word_at(a), 32'((a + 1) % 256));
   endtask

   task automatic next_cycle();
      @(posedge clk1);
      #1;
   endtask

   task automatic drain(input int unsigned n);
      repeat (n) next_cycle();
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_req"},     32'(imem_req), 32'd0);
      check({tag, "_addr"},    32'(imem_addr), 32'd0);
      check({tag, "_valid"},   32'(id_valid), 32'd0);
      check({tag, "_ir"},      id_ir, 32'd0);
      check({tag, "_npc"},     id_npc, 32'd0);
      check({tag, "_stopped"}, 32'(fetch_stopped), 32'd0);
   endtask

   task automatic do_reset(input int unsigned cycles);
      reset = 1'b1;
      for (int unsigned i = 0; i < cycles; i++) begin
         @(negedge clk1);
         if (i == cycles - 1) check_all_zero("rst");
         next_cycle();
      end
      reset = 1'b0;
   endtask

   always @(negedge clk1) begin
      if (!reset && !redirect_valid && id_valid === 1'b1 && id_ready) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL sb_extra: got ir 0x%08h npc 0x%08h, expected no word", id_ir, id_npc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("sb_ir", id_ir, e.ir);
            check("sb_npc", id_npc, e.npc);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int reqs;
      for (int i = 0; i < 256; i++) mem[i] = word_at(i);

      // Streaming fetch after reset release.
      halt = 1'b0;
      id_ready = 1'b1;
      do_reset(2);
      for (int unsigned a = 0; a < 4; a++) expect_word(a);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk1);
         check("t1_req", 32'(imem_req), 32'd1);
         check("t1_addr", 32'(imem_addr), 32'(k));
         if (k == 2) begin
            check("t1_first_valid", 32'(id_valid), 32'd1);
            check("t1_first_ir", id_ir, 32'h0400_0001);
            check("t1_first_npc", id_npc, 32'd1);
         end
         if (k == 3) check("t1_second_ir", id_ir, 32'h0400_0002);
         next_cycle();
      end
      halt = 1'b1;
      @(negedge clk1);
      check("t1_halt_req", 32'(imem_req), 32'd0);
      drain(6);
      @(negedge clk1);
      check("t1_empty_valid", 32'(id_valid), 32'd0);
      check("t1_empty_ir", id_ir, 32'd0);
      check("t1_empty_npc", id_npc, 32'd0);
      check("t1_sb_left", 32'(sb.size()), 32'd0);

      // Backpressure: queue fills, then drains without loss.
      halt = 1'b0;
      id_ready = 1'b0;
      do_reset(2);
      reqs = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk1);
         if (imem_req) begin
            check("t2_addr", 32'(imem_addr), 32'(reqs));
            reqs++;
         end
         next_cycle();
      end
      check("t2_req_count", 32'(reqs), 32'd4);
      for (int unsigned a = 0; a < 9; a++) expect_word(a);
      id_ready = 1'b1;
      @(negedge clk1);
      check("t2_full_req", 32'(imem_req), 32'd0);
      check("t2_full_valid", 32'(id_valid), 32'd1);
      check("t2_full_head", id_ir, 32'h0400_0001);
      next_cycle();
      @(negedge clk1);
      check("t2_resume_req", 32'(imem_req), 32'd1);
      check("t2_resume_addr", 32'(imem_addr), 32'd4);
      drain(5);
      halt = 1'b1;
      drain(8);
      check("t2_sb_left", 32'(sb.size()), 32'd0);

      // Redirect with three queued and one in flight.
      halt = 1'b0;
      id_ready = 1'b0;
      do_reset(2);
      drain(4);
      redirect_valid = 1'b1;
      redirect_pc = 8'h40;
      @(negedge clk1);
      check("t3_pre_valid", 32'(id_valid), 32'd1);
      check("t3_redir_req", 32'(imem_req), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      for (int unsigned a = 8'h40; a < 8'h43; a++) expect_word(a);
      @(negedge clk1);
      check("t3_flushed_valid", 32'(id_valid), 32'd0);
      check("t3_req", 32'(imem_req), 32'd1);
      check("t3_addr", 32'(imem_addr), 32'h40);
      drain(2);
      @(negedge clk1);
      check("t3_first_npc", id_npc, 32'h41);
      next_cycle();
      halt = 1'b1;
      drain(8);
      check("t3_sb_left", 32'(sb.size()), 32'd0);

      // Halt opcode self-stop, drain, and restart by redirect.
      mem[5] = 32'hFC00_0000;
      halt = 1'b0;
      id_ready = 1'b1;
      do_reset(2);
      for (int unsigned a = 0; a < 5; a++) expect_word(a);
      expect_raw(32'hFC00_0000, 32'd6);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk1);
         if (k < 6) begin
            check("t4_req", 32'(imem_req), 32'd1);
            check("t4_addr", 32'(imem_addr), 32'(k));
         end else begin
            check("t4_stopped_req", 32'(imem_req), 32'd0);
         end
         if (k == 7) check("t4_fetch_stopped", 32'(fetch_stopped), 32'd1);
         next_cycle();
      end
      check("t4_sb_left", 32'(sb.size()), 32'd0);
      redirect_valid = 1'b1;
      redirect_pc = '0;
      expect_word(0);
      @(negedge clk1);
      check("t4_redir_req", 32'(imem_req), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      @(negedge clk1);
      check("t4_restart_stopped", 32'(fetch_stopped), 32'd0);
      check("t4_restart_req", 32'(imem_req), 32'd1);
      check("t4_restart_addr", 32'(imem_addr), 32'd0);
      next_cycle();
      halt = 1'b1;
      drain(6);
      check("t4_sb_end", 32'(sb.size()), 32'd0);
      mem[5] = word_at(5);

      // PC wrap from 0xFF to 0x00.
      halt = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 8'hFF;
      @(negedge clk1);
      check("t5_redir_req", 32'(imem_req), 32'd0);
      next_cycle();
      redirect_valid = 1'b0;
      expect_raw(32'h0400_0100, 32'd0);
      expect_raw(32'h0400_0001, 32'd1);
      @(negedge clk1);
      check("t5_addr_ff", 32'(imem_addr), 32'hFF);
      next_cycle();
      @(negedge clk1);
      check("t5_addr_00_req", 32'(imem_req), 32'd1);
      check("t5_addr_00", 32'(imem_addr), 32'd0);
      next_cycle();
      halt = 1'b1;
      drain(6);
      check("t5_sb_left", 32'(sb.size()), 32'd0);

      // One-cycle reset with the queue full.
      halt = 1'b0;
      id_ready = 1'b0;
      do_reset(2);
      drain(8);
      @(negedge clk1);
      check("t6_full_valid", 32'(id_valid), 32'd1);
      check("t6_full_req", 32'(imem_req), 32'd0);
      next_cycle();
      reset = 1'b1;
      @(negedge clk1);
      check_all_zero("t6_rst");
      next_cycle();
      reset = 1'b0;
      id_ready = 1'b1;
      expect_word(0);
      @(negedge clk1);
      check("t6_req", 32'(imem_req), 32'd1);
      check("t6_addr", 32'(imem_addr), 32'd0);
      next_cycle();
      halt = 1'b1;
      drain(6);
      @(negedge clk1);
      check("t6_end_valid", 32'(id_valid), 32'd0);
      check("t6_sb_left", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of queue entries; power of two, minimum 2.
REQ-002 Parameter AW, default 8: instruction-memory address width (256 words).
REQ-003 clk1  input  1  pipeline clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the clk1 rising edge.
REQ-005 imem_req  output  1  read request to instruction memory this cycle.
REQ-006 imem_addr  output  AW  word address of the request.
REQ-007 imem_rdata  input  32  read data, valid exactly one cycle after the request.
REQ-008 redirect_valid  input  1  taken branch or jump from execute; flushes the queue.
REQ-009 redirect_pc  input  AW  target word address accompanying redirect_valid.
REQ-010 halt  input  1  external stall; blocks new requests while high.
REQ-011 id_valid  output  1  queue head holds a valid instruction for decode.
REQ-012 id_ir  output  32  instruction word at the queue head.
REQ-013 id_npc  output  32  address of the head instruction plus 1, zero-extended to 32 bits.
REQ-014 id_ready  input  1  decode accepts the head this cycle.
REQ-015 fetch_stopped  output  1  fetch has self-stopped after fetching a Halt opcode.

Function
REQ-016 PC: AW-bit register; wraps 2^AW-1 -> 0; advances by 1 on each issued request.
REQ-017 Issue condition for a request: not halt, not redirect_valid, not fetch_stopped, and (occupancy + in-flight) < DEPTH.
REQ-018 When a request issues, imem_req = 1 and imem_addr = PC; otherwise imem_req = 0.
REQ-019 Response capture: imem_rdata is pushed one cycle after issue, together with npc = issued address + 1 (wrapped to AW bits, then zero-extended).
REQ-020 Minimum latency: request in cycle N, data returns in N+1, id_valid in N+2; there is no bypass path.
REQ-021 Pop: when id_valid and id_ready are both high, the head is removed at the clock edge.
REQ-022 When empty, id_valid = 0, id_ir = 0, id_npc = 0.
REQ-023 A push and a pop in the same cycle keep occupancy unchanged, including at occupancy DEPTH.
REQ-024 No overflow is possible; the in-flight accounting in REQ-017 guarantees a free slot for every response.
REQ-025 Redirect has highest priority:
- queue empties; any in-flight response is discarded next cycle;
- PC <= redirect_pc; fetch_stopped <= 0;
- no request in the redirect cycle; the first request at redirect_pc issues the following cycle.
- A simultaneous pop or push in the redirect cycle is ignored.
REQ-026 Self-stop: when a pushed word has bits [31:26] = 6'b111111 (Halt), fetch_stopped <= 1 and no further requests issue until redirect or reset. Entries already queued remain drainable.
REQ-027 Halt input: requests stop in the cycle halt is high; an in-flight response is still captured; draining continues normally.
REQ-028 State machine, three states:
- FETCH -> STALL when halt is high or the queue is full including in-flight;
- STALL -> FETCH when the condition clears;
- any state -> STOPPED on a Halt-opcode push;
- STOPPED -> FETCH only on redirect_valid;
- redirect from any state -> FETCH.

Reset
REQ-029 While reset is high, PC = 0, the queue is emptied, the in-flight flag is cleared, the state is FETCH, and all outputs are 0.
REQ-030 Reset asserted mid-operation discards queued and in-flight data; the first request after release addresses 0 in the first cycle reset is low.

Structure
REQ-031 A shared package holds: opcode constants (Nop 6'b000000, Halt 6'b111111, branch/Jmp/Beq/Blt/Bgt codes), default AW and DEPTH, and the fetch state enumeration.
REQ-032 One sub-module, ifq_fifo: synchronous DEPTH x 64 FIFO (ir and npc) with flush, push, pop, count, and full/empty; instr_fetch_queue holds PC, the in-flight flag, and the state machine.

Verification
REQ-033 Reset release, mem[0..3] = 0x04000001..0x04000004, id_ready = 1:
- imem_addr = 0,1,2,3 on consecutive cycles;
- id_ir = 0x04000001 with id_npc = 1 two cycles after the first request;
- then one instruction per cycle.
REQ-034 id_ready = 0 for 10 cycles:
- exactly 4 requests issue, then imem_req = 0;
- id_valid remains 1 with head 0x04000001.
- Raising id_ready resumes one pop per cycle with no lost or duplicated words.
REQ-035 Redirect with redirect_pc = 0x40 while 3 entries are queued and 1 request is in flight:
- next cycle id_valid = 0;
- the following cycle imem_addr = 0x40;
- first delivered id_npc = 0x41.
REQ-036 mem[5] = 0xFC000000 (Halt):
- after address 5 is requested, no further requests issue and fetch_stopped = 1;
- entries 0..5 drain;
- a subsequent redirect to 0 restarts fetch.
REQ-037 PC = 0xFF: requests at 0xFF then 0x00; id_npc values 0x00000000 and 0x00000001.
REQ-038 Reset asserted for 1 cycle with the queue full: all outputs 0, and the next request is at address 0.
